// File: rtl/sram_arbiter.sv
// Two-master arbiter (instruction fetch, data load/store) for one single-port SRAM.
// Data wins by default; an anti-starvation counter hands inst the port after STARVE_MAX losses.
module sram_arbiter #(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_gnt,
    output logic        inst_rvalid,
    output logic [31:0] inst_rdata,

    input  logic        data_en,
    input  logic [3:0]  data_we,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_gnt,
    output logic        data_rvalid,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,

    output logic        stallreq_if,
    output logic        stallreq_ex
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } own_e;

    own_e             rd_own_q, rd_own_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             starve_hit;
    logic             inst_win;

    // State register: owner of the read in flight and the inst-lost counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_own_q <= OWN_NONE;
            starve_q <= '0;
        end else begin
            rd_own_q <= rd_own_d;
            starve_q <= starve_d;
        end
    end

    // Next-state logic
    always_comb begin
        rd_own_d = OWN_NONE;
        starve_d = starve_q;
        if (inst_gnt) begin
            rd_own_d = OWN_INST;
        end else if (data_gnt && (data_we == 4'b0000)) begin
            rd_own_d = OWN_DATA;
        end

        if (flush || inst_gnt || !inst_req) begin
            starve_d = '0;
        end else if (data_gnt && (starve_q < CNT_W'(STARVE_MAX))) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Output logic: grants, SRAM mux, read return and stalls
    always_comb begin
        starve_hit  = (starve_q == CNT_W'(STARVE_MAX));
        // A flushed fetch cannot take the port, so it also cannot pre-empt data
        inst_win    = inst_req && !flush && starve_hit;

        inst_gnt    = 1'b0;
        data_gnt    = 1'b0;
        inst_rvalid = 1'b0;
        inst_rdata  = '0;
        data_rvalid = 1'b0;
        data_rdata  = '0;
        sram_en     = 1'b0;
        sram_we     = '0;
        sram_addr   = '0;
        sram_wdata  = '0;
        stallreq_if = 1'b0;
        stallreq_ex = 1'b0;

        if (!rst) begin
            data_gnt = data_en && !inst_win;
            inst_gnt = inst_req && !flush && !data_gnt;

            if (data_gnt) begin
                sram_en    = 1'b1;
                sram_we    = data_we;
                sram_addr  = data_addr;
                sram_wdata = data_wdata;
            end else if (inst_gnt) begin
                sram_en    = 1'b1;
                sram_addr  = inst_addr;
            end

            // A same-cycle flush kills the fetch response
            if ((rd_own_q == OWN_INST) && !flush) begin
                inst_rvalid = 1'b1;
                inst_rdata  = sram_rdata;
            end
            if (rd_own_q == OWN_DATA) begin
                data_rvalid = 1'b1;
                data_rdata  = sram_rdata;
            end

            stallreq_if = inst_req && !inst_gnt;
            stallreq_ex = data_en && !data_gnt;
        end
    end

endmodule
